// File: rtl/seq_step_controller.sv
// Step-sequencer controller: rotary/button editing of an 8-step note pattern plus a tempo step clock.
// Optional build macro SEQ_CURSOR_WRAP_EN makes the browse cursor wrap instead of saturating.
module seq_step_controller #(
  parameter int STEP_TICKS = 3_000_000,
  parameter int NOTE_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        rotary_position,
  input  logic              button_pressed,
  input  logic              run_en,
  output logic [2:0]        cursor,
  output logic              edit_mode,
  output logic [2:0]        play_step,
  output logic [NOTE_W-1:0] play_note,
  output logic [NOTE_W-1:0] cursor_note,
  output logic              step_strobe
);

  localparam int              TW       = $clog2(STEP_TICKS);
  localparam logic [TW-1:0]   TERM     = TW'(STEP_TICKS - 1);
  localparam logic [NOTE_W-1:0] NOTE_MAX = '1;

  typedef enum logic {
    ST_BROWSE = 1'b0,
    ST_EDIT   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [2:0]        r_prev_pos;
  logic              r_btn_q;
  logic [2:0]        r_cursor;
  logic [NOTE_W-1:0] r_pattern [8];
  logic [2:0]        r_play_step;
  logic [TW-1:0]     r_timer;
  logic              r_strobe;

  logic [2:0]        w_delta;
  logic              w_inc;
  logic              w_dec;
  logic              w_btn_evt;
  logic              w_cur_inc;
  logic              w_cur_dec;
  logic              w_note_inc;
  logic              w_note_dec;
  logic [2:0]        w_cursor_nxt;
  logic [NOTE_W-1:0] w_note_cur;
  logic [NOTE_W-1:0] w_note_nxt;
  logic              w_term;

  // Mod-8 difference: 7->0 yields 1 (clockwise), 0->7 yields 7 (counter-clockwise).
  assign w_delta   = rotary_position - r_prev_pos;
  assign w_inc     = (w_delta == 3'd1);
  assign w_dec     = (w_delta == 3'd7);
  assign w_btn_evt = button_pressed & ~r_btn_q;

  // Rotary events act on the pre-transition state; the button toggles the state on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_inc   = 1'b0;
    w_cur_dec   = 1'b0;
    w_note_inc  = 1'b0;
    w_note_dec  = 1'b0;
    case (r_state)
      ST_BROWSE: begin
        w_cur_inc = w_inc;
        w_cur_dec = w_dec;
        if (w_btn_evt) w_state_nxt = ST_EDIT;
      end
      ST_EDIT: begin
        w_note_inc = w_inc;
        w_note_dec = w_dec;
        if (w_btn_evt) w_state_nxt = ST_BROWSE;
      end
      default: w_state_nxt = ST_BROWSE;
    endcase
  end

  always_comb begin
    w_cursor_nxt = r_cursor;
`ifdef SEQ_CURSOR_WRAP_EN
    if (w_cur_inc)      w_cursor_nxt = r_cursor + 3'd1;
    else if (w_cur_dec) w_cursor_nxt = r_cursor - 3'd1;
`else
    if (w_cur_inc && (r_cursor != 3'd7))      w_cursor_nxt = r_cursor + 3'd1;
    else if (w_cur_dec && (r_cursor != 3'd0)) w_cursor_nxt = r_cursor - 3'd1;
`endif
  end

  assign w_note_cur = r_pattern[r_cursor];

  always_comb begin
    w_note_nxt = w_note_cur;
    if (w_note_inc && (w_note_cur != NOTE_MAX))             w_note_nxt = w_note_cur + 1'b1;
    else if (w_note_dec && (w_note_cur != '0)) w_note_nxt = w_note_cur - 1'b1;
  end

  assign w_term = run_en && (r_timer == TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_BROWSE;
      r_prev_pos <= rotary_position;
      r_btn_q    <= button_pressed;
      r_cursor   <= 3'd0;
      for (int i = 0; i < 8; i++) r_pattern[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_pos <= rotary_position;
      r_btn_q    <= button_pressed;
      r_cursor   <= w_cursor_nxt;
      if (w_note_inc || w_note_dec) r_pattern[r_cursor] <= w_note_nxt;
    end
  end

  // Step clock: holds while run_en is low, so a low period stretches the step by that many cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_play_step <= 3'd0;
      r_strobe    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_term) begin
        r_timer     <= '0;
        r_play_step <= r_play_step + 3'd1;
        r_strobe    <= 1'b1;
      end else if (run_en) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign cursor      = r_cursor;
  assign edit_mode   = (r_state == ST_EDIT);
  assign play_step   = r_play_step;
  assign step_strobe = r_strobe;
  assign play_note   = r_pattern[r_play_step];
  assign cursor_note = r_pattern[r_cursor];

endmodule

// File: tb/tb_seq_step_controller.sv
// Directed bench for seq_step_controller with STEP_TICKS=4; expectations follow SEQ_CURSOR_WRAP_EN if defined.
module tb_seq_step_controller;

  localparam int TICKS = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] rotary_position;
  logic       button_pressed;
  logic       run_en;
  logic [2:0] cursor;
  logic       edit_mode;
  logic [2:0] play_step;
  logic [2:0] play_note;
  logic [2:0] cursor_note;
  logic       step_strobe;

  int n_vec = 0;
  int n_err = 0;

  seq_step_controller #(.STEP_TICKS(TICKS), .NOTE_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rotary_position(rotary_position),
    .button_pressed (button_pressed),
    .run_en         (run_en),
    .cursor         (cursor),
    .edit_mode      (edit_mode),
    .play_step      (play_step),
    .play_note      (play_note),
    .cursor_note    (cursor_note),
    .step_strobe    (step_strobe)
  );

  // Clock / timeout
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rot(input int dir);
    rotary_position = rotary_position + 3'(dir);
    tick();
  endtask

  initial begin
    int gap;
    int n;

    // Reset with encoder at 5 and button held
    rst_n = 1'b0; rotary_position = 3'd5; button_pressed = 1'b1; run_en = 1'b0;
    tick(); tick();
    check("rst_cursor", cursor, 0);
    check("rst_edit", edit_mode, 0);
    check("rst_play_step", play_step, 0);
    check("rst_strobe", step_strobe, 0);
    check("rst_cursor_note", cursor_note, 0);
    check("rst_play_note", play_note, 0);

    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_cursor", cursor, 0);
    check("post_rst_edit", edit_mode, 0);

    // Browse: 5->0 is a jump of 3 and is ignored
    button_pressed = 1'b0;
    rotary_position = 3'd0; tick();
    check("jump3_cursor", cursor, 0);
    rotary_position = 3'd1; tick();
    check("browse_inc1", cursor, 1);
    rotary_position = 3'd2; tick();
    check("browse_inc2", cursor, 2);
    rotary_position = 3'd1; tick();
    check("browse_dec", cursor, 1);
    rotary_position = 3'd2; tick();
    check("browse_inc3", cursor, 2);
    rotary_position = 3'd6; tick();
    check("jump4_cursor", cursor, 2);

    // Enter edit, saturate pattern[2] at 7
    button_pressed = 1'b1; tick();
    check("edit_enter", edit_mode, 1);
    check("edit_cursor_kept", cursor, 2);
    for (int i = 0; i < 9; i++) begin
      rot(1);
      check("edit_inc_note", cursor_note, (i + 1 > 7) ? 7 : i + 1);
    end
    check("edit_cursor_fixed", cursor, 2);
    rot(-1);
    check("edit_dec_note", cursor_note, 6);
    rot(1);
    check("edit_reinc_note", cursor_note, 7);
    button_pressed = 1'b0; tick();
    check("edit_release_hold", edit_mode, 1);
    button_pressed = 1'b1; tick();
    check("edit_exit", edit_mode, 0);
    check("edit_exit_note", cursor_note, 7);
    button_pressed = 1'b0; tick();

    // Button edge and +1 together from BROWSE at cursor 2
    button_pressed = 1'b1; rot(1);
    check("simul_cursor", cursor, 3);
    check("simul_edit", edit_mode, 1);
    check("simul_note3", cursor_note, 0);
    button_pressed = 1'b0; tick();
    button_pressed = 1'b1; tick();
    check("simul_back_browse", edit_mode, 0);
    button_pressed = 1'b0; tick();

    // Cursor boundary at 7
    repeat (4) rot(1);
    check("cursor_at7", cursor, 7);
    rot(1);
`ifdef SEQ_CURSOR_WRAP_EN
    check("cursor_past7", cursor, 0);
`else
    check("cursor_past7", cursor, 7);
`endif

    // Note low saturation at the boundary cursor
    button_pressed = 1'b1; tick();
    check("lowsat_edit", edit_mode, 1);
    rot(-1);
    check("lowsat_note", cursor_note, 0);
    rot(1);
    check("lowsat_inc", cursor_note, 1);
`ifdef SEQ_CURSOR_WRAP_EN
    check("lowsat_play_note", play_note, 1);
`else
    check("lowsat_play_note", play_note, 0);
`endif
    rot(-1);
    check("lowsat_restore", cursor_note, 0);
    button_pressed = 1'b0; tick();
    button_pressed = 1'b1; tick();
    check("lowsat_exit", edit_mode, 0);
    button_pressed = 1'b0; tick();

    // Playback: strobe every 4 cycles, play_step wraps, play_note tracks pattern
    run_en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check("run_strobe", step_strobe, (c % TICKS) == 0);
      check("run_play_step", play_step, (c / TICKS) % 8);
      check("run_play_note", play_note, (((c / TICKS) % 8) == 2) ? 7 : 0);
    end

    // run_en low for 3 cycles stretches the period to 7
    gap = 0;
    tick(); gap++;
    run_en = 1'b0;
    repeat (3) begin tick(); gap++; end
    run_en = 1'b1;
    while (gap < 20) begin
      tick(); gap++;
      if (step_strobe) break;
    end
    check("gap_cycles", gap, 7);
    check("gap_play_step", play_step, 3);
    run_en = 1'b0;

    // Edit the step that is playing (step 3)
`ifdef SEQ_CURSOR_WRAP_EN
    repeat (3) rot(1);
`else
    repeat (4) rot(-1);
`endif
    check("live_cursor", cursor, 3);
    button_pressed = 1'b1; tick();
    rot(1);
    check("live_cursor_note", cursor_note, 1);
    check("live_play_note", play_note, 1);
    check("live_play_step", play_step, 3);

    // Reset mid-operation from EDIT
    rst_n = 1'b0; tick();
    check("mrst_cursor", cursor, 0);
    check("mrst_edit", edit_mode, 0);
    check("mrst_play_step", play_step, 0);
    check("mrst_strobe", step_strobe, 0);
    rst_n = 1'b1; run_en = 1'b1;
    n = 0;
    while (n < 20) begin
      tick(); n++;
      if (step_strobe) break;
    end
    check("first_strobe_cycles", n, TICKS);
    check("first_strobe_step", play_step, 1);
    check("mrst_note_cleared", play_note, 0);
    check("mrst_hold_button", edit_mode, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_step_controller.md
# seq_step_controller

Step-sequencer controller that turns the debounced rotary-encoder outputs (`rotary_position`, `button_pressed`) into an editable 8-step note pattern and a tempo-driven playback pointer. It sits between the rotary encoder block and the note/LED output logic. It owns the pattern storage, the edit cursor, the browse/edit mode state machine and the step clock.

## Interface
- `STEP_TICKS`, default 3_000_000: clock cycles per playback step (250 ms at 12 MHz); minimum 2.
- `NOTE_W`, default 3: width of each stored note value.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset; one clock domain only.
- `rotary_position` in 3: encoder position from the encoder block; 7→0 is one clockwise detent.
- `button_pressed` in 1: encoder button level, high while pressed.
- `run_en` in 1: high = playback advances; low = step timer holds.
- `cursor` out 3: step currently selected for editing.
- `edit_mode` out 1: high in EDIT state.
- `play_step` out 3: step currently playing.
- `play_note` out NOTE_W: `pattern[play_step]`.
- `cursor_note` out NOTE_W: `pattern[cursor]`.
- `step_strobe` out 1: one-cycle pulse when `play_step` advances.

## Operation
- Storage: 8 × NOTE_W registers `pattern[0..7]`.
- Rotary delta: `d = rotary_position − prev_pos` (3-bit, mod 8), with `prev_pos` registered every cycle.
  - `d == 1`: +1 event.
  - `d == 7`: −1 event.
  - Any other nonzero `d`: ignored (no action); `prev_pos` still updates.
- Button: rising edge of `button_pressed` against a registered copy gives `btn_evt`.
- FSM has 2 states; the reset state is BROWSE.
  - BROWSE: ±1 events move `cursor`. `btn_evt` → EDIT.
  - EDIT: ±1 events change `pattern[cursor]`, saturating at 0 and at 2^NOTE_W−1 (no wrap). `btn_evt` → BROWSE.
- Simultaneous `btn_evt` and rotary event in one cycle: the rotary event is applied per the current (pre-transition) state; the state toggles on the same edge.
- Step timer counts 0..STEP_TICKS−1 while `run_en`=1 and holds its value while `run_en`=0.
  - On terminal count: the counter returns to 0, `play_step` increments mod 8 (7→0 always wraps), and `step_strobe`=1 for exactly that one cycle.
- Editing the step that is playing: `play_note` reflects the new value 1 cycle after the edit edge. It does not wait for the next strobe.
- `play_note` and `cursor_note` are combinational reads of the registered `pattern`.

## Timing
- Reset values (`rst_n`=0 at a rising edge):
  - `cursor`=0, `play_step`=0, `edit_mode`=0, `step_strobe`=0, timer=0, all `pattern`=0.
  - `prev_pos` loads the current `rotary_position`, so there is no spurious delta after reset.
  - The button history register loads the current `button_pressed`, so a button held through reset gives no event.
- Reset mid-operation: same as above on the next edge, regardless of state or timer value.
- Latency from an input change sampled at edge N:
  - Updated `cursor`, `pattern` or `edit_mode` is visible after edge N+1.
  - `cursor_note` and `play_note` follow combinationally from that point.
- Step period: exactly STEP_TICKS cycles between successive `step_strobe` pulses while `run_en` stays high. Deasserting `run_en` stretches the period by the number of low cycles.
- First strobe after reset with `run_en` held high: STEP_TICKS cycles after reset deasserts.
- No handshake: every input is sampled each cycle, and a new rotary event may be accepted every cycle.

## Configuration
- `SEQ_CURSOR_WRAP_EN` defined: `cursor` wraps in BROWSE, so +1 at 7 → 0 and −1 at 0 → 7.
- `SEQ_CURSOR_WRAP_EN` not defined: `cursor` saturates; +1 at 7 stays at 7 and −1 at 0 stays at 0.
- Note-value editing saturates in both builds.
- `play_step` wraps in both builds.

## Test plan
- Reset with `rotary_position`=5 and `button_pressed`=1, release reset, hold inputs → `cursor`=0, `edit_mode`=0, no `cursor` change, no mode change, all notes 0.
- In BROWSE, step `rotary_position` 0→1→2, then 2→1 → `cursor` goes 1, 2, 1, each one cycle after the input change. A jump of 2→6 → no change.
- Button rising edge, then rotary +1 ×9 → `edit_mode`=1 and `pattern[cursor]` saturates at 7. Second button press → `edit_mode`=0.
- `STEP_TICKS`=4, `run_en`=1 for 40 cycles → `step_strobe` every 4 cycles and `play_step` goes 0..7 then 0. Drop `run_en` for 3 cycles → the gap between strobes is 7 cycles.
- Button edge and rotary +1 in the same cycle from BROWSE at `cursor`=2 → `cursor`=3 and `edit_mode`=1 after the same edge, with the pattern unchanged.
- With `cursor`=7 in BROWSE, rotary +1 → `cursor`=0 with the macro defined, `cursor`=7 without it. Run both builds.
